// File: rtl/fpu_addsub_ctrl.sv
// rtl/fpu_addsub_ctrl.sv - issue/collect controller for an external fp add/sub unit
//
// Accepts an ADD/SUB request on start, registers operands into the external
// fadd, waits LAT cycles, captures result/flags and presents them with a
// one-cycle valid_out. Keeps sticky accumulated flags and NZCV ALU flags.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-low reset
//   start, op_code           request strobe (IDLE only); 00 ADD, 01 SUB, 1x illegal
//   op_a, op_b               operands (fp16 in [15:0] when mode_fp=0)
//   mode_fp, round_mode      0 half / 1 single; 1 RNE / 0 truncate
//   clr_flags                synchronous clear of fflags_acc
//   fa_op_a/b, fa_round,     registered drive into the fadd
//   fa_mode
//   fa_result, fa_flags      fadd result and {NV,OF,UF,-,NX}
//   busy, valid_out          busy from accept through valid_out; result strobe
//   result, flags, alu_flags captured result/flags and {N,Z,C,V}, held
//   fflags_acc               sticky OR of flags of every completed op
module fpu_addsub_ctrl #(
  parameter int unsigned LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op_code,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        mode_fp,
  input  logic        round_mode,
  input  logic        clr_flags,
  output logic [31:0] fa_op_a,
  output logic [31:0] fa_op_b,
  output logic        fa_round,
  output logic        fa_mode,
  input  logic [31:0] fa_result,
  input  logic [4:0]  fa_flags,
  output logic        busy,
  output logic        valid_out,
  output logic [31:0] result,
  output logic [4:0]  flags,
  output logic [3:0]  alu_flags,
  output logic [4:0]  fflags_acc
);

  if (LAT < 1 || LAT > 15) begin : g_bad_lat
    $error("fpu_addsub_ctrl: LAT must be in 1..15");
  end

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        mode_q, mode_d;
  logic        illegal_q, illegal_d;
  logic [31:0] fa_op_a_q, fa_op_a_d;
  logic [31:0] fa_op_b_q, fa_op_b_d;
  logic        fa_round_q, fa_round_d;
  logic        fa_mode_q, fa_mode_d;
  logic [31:0] result_q, result_d;
  logic [4:0]  flags_q, flags_d;
  logic [3:0]  alu_q, alu_d;
  logic [4:0]  acc_q, acc_d;

  logic        capture;
  logic [31:0] cap_result;
  logic [4:0]  cap_flags;
  logic [31:0] b_sel;
  logic [31:0] sign_mask;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mode_d     = mode_q;
    illegal_d  = illegal_q;
    fa_op_a_d  = fa_op_a_q;
    fa_op_b_d  = fa_op_b_q;
    fa_round_d = fa_round_q;
    fa_mode_d  = fa_mode_q;
    result_d   = result_q;
    flags_d    = flags_q;
    alu_d      = alu_q;
    acc_d      = acc_q;
    capture    = 1'b0;

    // Half mode: upper 16 bits are never forwarded; SUB flips the sign bit of
    // the active format unconditionally, NaN included.
    b_sel     = mode_fp ? op_b : {16'h0000, op_b[15:0]};
    sign_mask = mode_fp ? 32'h8000_0000 : 32'h0000_8000;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = WAIT;
          cnt_d     = 4'(LAT - 1);
          mode_d    = mode_fp;
          illegal_d = op_code[1];
          if (op_code[1]) begin
            fa_op_a_d  = 32'h0;
            fa_op_b_d  = 32'h0;
            fa_round_d = 1'b0;
            fa_mode_d  = 1'b0;
          end else begin
            fa_op_a_d  = mode_fp ? op_a : {16'h0000, op_a[15:0]};
            fa_op_b_d  = op_code[0] ? (b_sel ^ sign_mask) : b_sel;
            fa_round_d = round_mode;
            fa_mode_d  = mode_fp;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          capture = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Illegal ops return the canonical quiet NaN of the latched format with NV.
    if (illegal_q) begin
      cap_result = mode_q ? 32'h7FC0_0000 : 32'h0000_7E00;
      cap_flags  = 5'b10000;
    end else begin
      cap_result = mode_q ? fa_result : {16'h0000, fa_result[15:0]};
      cap_flags  = fa_flags;
    end

    if (capture) begin
      result_d = cap_result;
      flags_d  = cap_flags;
      alu_d[3] = mode_q ? cap_result[31] : cap_result[15];
      alu_d[2] = mode_q ? (cap_result[30:0] == 31'h0) : (cap_result[14:0] == 15'h0);
      alu_d[1] = 1'b0;
      alu_d[0] = cap_flags[3];
    end

    // A clear coinciding with a capture keeps only the new op's flags.
    if (clr_flags) begin
      acc_d = capture ? cap_flags : 5'b00000;
    end else if (capture) begin
      acc_d = acc_q | cap_flags;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      mode_q     <= 1'b0;
      illegal_q  <= 1'b0;
      fa_op_a_q  <= 32'h0;
      fa_op_b_q  <= 32'h0;
      fa_round_q <= 1'b0;
      fa_mode_q  <= 1'b0;
      result_q   <= 32'h0;
      flags_q    <= 5'h0;
      alu_q      <= 4'h0;
      acc_q      <= 5'h0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mode_q     <= mode_d;
      illegal_q  <= illegal_d;
      fa_op_a_q  <= fa_op_a_d;
      fa_op_b_q  <= fa_op_b_d;
      fa_round_q <= fa_round_d;
      fa_mode_q  <= fa_mode_d;
      result_q   <= result_d;
      flags_q    <= flags_d;
      alu_q      <= alu_d;
      acc_q      <= acc_d;
    end
  end

  assign fa_op_a    = fa_op_a_q;
  assign fa_op_b    = fa_op_b_q;
  assign fa_round   = fa_round_q;
  assign fa_mode    = fa_mode_q;
  assign valid_out  = (state_q == DONE);
  // busy covers the accept cycle itself, hence the start term.
  assign busy       = (state_q != IDLE) || start;
  assign result     = result_q;
  assign flags      = flags_q;
  assign alu_flags  = alu_q;
  assign fflags_acc = acc_q;

endmodule
